// File: rtl/digit_entry.sv
// Input conditioning for the combination lock: synchronizes and debounces the
// digit key, validates the switch value as 0-9, and counts accepted digits.
module digit_entry #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int NUM_DIGITS      = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_n,
   input  logic [9:0] sw,
   input  logic       clear,
   output logic       digit_valid,
   output logic [3:0] digit,
   output logic       digit_err,
   output logic [2:0] entry_count,
   output logic       entry_done,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DEB_PRESS = 3'd1,
      CAPTURE   = 3'd2,
      WAIT_REL  = 3'd3,
      DEB_REL   = 3'd4,
      DONE      = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Arming must outlast the two cycles of "released" the synchronizer shows after reset.
   localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'((DEBOUNCE_CYCLES < 3) ? 2 : DEBOUNCE_CYCLES - 1);
   localparam logic [2:0]       NUM_D    = 3'(NUM_DIGITS);

   logic             btn_meta_q, btn_sync_q;
   logic [9:0]       sw_meta_q, sw_sync_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;
   logic [3:0]       digit_q, digit_d;
   logic [2:0]       count_q, count_d;
   logic             dv_q, dv_d;
   logic             de_q, de_d;
   logic             done_q;
   logic             busy_q;

   // Two-flop synchronizers for the asynchronous button and switches.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         btn_meta_q <= 1'b1;
         btn_sync_q <= 1'b1;
         sw_meta_q  <= 10'd0;
         sw_sync_q  <= 10'd0;
      end else begin
         btn_meta_q <= btn_n;
         btn_sync_q <= btn_meta_q;
         sw_meta_q  <= sw;
         sw_sync_q  <= sw_meta_q;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         armed_q <= 1'b0;
         digit_q <= 4'd0;
         count_q <= 3'd0;
         dv_q    <= 1'b0;
         de_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         digit_q <= digit_d;
         count_q <= count_d;
         dv_q    <= dv_d;
         de_q    <= de_d;
         done_q  <= (count_q == NUM_D);
         busy_q  <= (state_d != IDLE) && (state_d != DONE);
      end
   end

   // Next-state logic; clear overrides every transition.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      digit_d = digit_q;
      count_d = count_q;
      dv_d    = 1'b0;
      de_d    = 1'b0;
      if (clear) begin
         count_d = 3'd0;
         cnt_d   = '0;
         state_d = btn_sync_q ? IDLE : WAIT_REL;
      end else begin
         case (state_q)
            IDLE: begin
               // After reset a held key must be seen released before it can start a press.
               if (!armed_q) begin
                  if (!btn_sync_q) begin
                     cnt_d = '0;
                  end else if (cnt_q == ARM_LAST) begin
                     armed_d = 1'b1;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else if (!btn_sync_q) begin
                  state_d = DEB_PRESS;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
            DEB_PRESS: begin
               if (btn_sync_q) begin
                  state_d = IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = CAPTURE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            CAPTURE: begin
               state_d = WAIT_REL;
               if (sw_sync_q <= 10'd9) begin
                  digit_d = sw_sync_q[3:0];
                  dv_d    = 1'b1;
                  if (count_q < NUM_D) begin
                     count_d = count_q + 3'd1;
                  end else begin
                     count_d = count_q;
                  end
               end else begin
                  de_d = 1'b1;
               end
            end
            WAIT_REL: begin
               if (btn_sync_q) begin
                  state_d = DEB_REL;
                  cnt_d   = '0;
               end else begin
                  state_d = WAIT_REL;
               end
            end
            DEB_REL: begin
               if (!btn_sync_q) begin
                  state_d = WAIT_REL;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = (count_q == NUM_D) ? DONE : IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign digit_valid = dv_q;
   assign digit_err   = de_q;
   assign digit       = digit_q;
   assign entry_count = count_q;
   assign entry_done  = done_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry with a short debounce window.
module tb_digit_entry;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_n;
   logic [9:0] sw;
   logic       clear;
   logic       digit_valid;
   logic [3:0] digit;
   logic       digit_err;
   logic [2:0] entry_count;
   logic       entry_done;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   digit_entry #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16), .NUM_DIGITS(6)) dut (
      .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .sw(sw), .clear(clear),
      .digit_valid(digit_valid), .digit(digit), .digit_err(digit_err),
      .entry_count(entry_count), .entry_done(entry_done), .busy(busy)
   );

   always #5 clk = ~clk;

   // Full press of 'hold' cycles followed by a 12-cycle release; edge k=1 is the first sampling edge.
   task automatic press_release(input logic [9:0] v, input int hold,
                                output int nv, output int ne, output logic [3:0] dig,
                                output int first_k, output logic done_after, output logic busy_held);
      logic prev;
      sw = v;
      repeat (4) @(negedge clk);
      nv = 0; ne = 0; dig = 4'd0; first_k = 0; done_after = 1'b0; busy_held = 1'b0; prev = 1'b0;
      btn_n = 1'b0;
      for (int k = 1; k <= hold + 12; k++) begin
         if (k == hold + 1) btn_n = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (prev) done_after = entry_done;
         prev = 1'b0;
         if (digit_valid) begin
            nv++;
            dig = digit;
            prev = 1'b1;
            if (first_k == 0) first_k = k;
         end
         if (digit_err) ne++;
         if (k == hold) busy_held = busy;
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; btn_n = 1'b1; sw = 10'd0; clear = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({digit_valid, digit, digit_err, entry_count, entry_done, busy} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 0", {digit_valid, digit, digit_err, entry_count, entry_done, busy});
      end
      rst_n = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_basic_press();
      int nv, ne, fk; logic [3:0] d; logic da, bh;
      press_release(10'd7, 20, nv, ne, d, fk, da, bh);
      n_checks++;
      if (fk !== 8) begin n_fail++; $display("FAIL basic_latency: pulse at edge %0d expected 8", fk); end
      n_checks++;
      if (nv !== 1 || ne !== 0) begin n_fail++; $display("FAIL basic_pulses: valid=%0d err=%0d expected 1/0", nv, ne); end
      n_checks++;
      if (d !== 4'd7 || entry_count !== 3'd1) begin n_fail++; $display("FAIL basic_digit: digit=%0d count=%0d expected 7/1", d, entry_count); end
      n_checks++;
      if (bh !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: held=%b after=%b expected 1/0", bh, busy); end
   endtask

   task automatic test_glitch();
      int nv; logic saw_busy;
      nv = 0; saw_busy = 1'b0;
      btn_n = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         if (k == 4) btn_n = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (digit_valid || digit_err) nv++;
         if (busy) saw_busy = 1'b1;
      end
      n_checks++;
      if (nv !== 0) begin n_fail++; $display("FAIL glitch_pulse: got %0d pulses expected 0", nv); end
      n_checks++;
      if (saw_busy !== 1'b1 || busy !== 1'b0 || entry_count !== 3'd1) begin
         n_fail++; $display("FAIL glitch_state: saw_busy=%b busy=%b count=%0d expected 1/0/1", saw_busy, busy, entry_count);
      end
   endtask

   task automatic test_bad_digit();
      int nv, ne, fk; logic [3:0] d; logic da, bh;
      press_release(10'd12, 10, nv, ne, d, fk, da, bh);
      n_checks++;
      if (ne !== 1 || nv !== 0) begin n_fail++; $display("FAIL bad_digit_pulses: err=%0d valid=%0d expected 1/0", ne, nv); end
      n_checks++;
      if (digit !== 4'd7 || entry_count !== 3'd1) begin n_fail++; $display("FAIL bad_digit_hold: digit=%0d count=%0d expected 7/1", digit, entry_count); end
   endtask

   task automatic test_full_entry();
      logic [9:0] seq [6];
      int nv, ne, fk; logic [3:0] d; logic da, bh;
      seq[0] = 10'd7; seq[1] = 10'd0; seq[2] = 10'd3; seq[3] = 10'd2; seq[4] = 10'd6; seq[5] = 10'd2;
      pulse_clear();
      n_checks++;
      if (entry_count !== 3'd0) begin n_fail++; $display("FAIL clear_count: got %0d expected 0", entry_count); end
      for (int i = 0; i < 6; i++) begin
         press_release(seq[i], 10, nv, ne, d, fk, da, bh);
         n_checks++;
         if (nv !== 1 || d !== seq[i][3:0] || entry_count !== 3'(i + 1) || da !== (i == 5)) begin
            n_fail++;
            $display("FAIL entry_digit%0d: valid=%0d digit=%0d count=%0d done_after=%b expected 1/%0d/%0d/%b",
                     i, nv, d, entry_count, da, seq[i], i + 1, (i == 5));
         end
      end
      n_checks++;
      if (entry_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL entry_done: done=%b busy=%b expected 1/0", entry_done, busy); end
      press_release(10'd4, 10, nv, ne, d, fk, da, bh);
      n_checks++;
      if (nv !== 0 || ne !== 0 || entry_count !== 3'd6 || digit !== 4'd2) begin
         n_fail++; $display("FAIL seventh_press: valid=%0d err=%0d count=%0d digit=%0d expected 0/0/6/2", nv, ne, entry_count, digit);
      end
   endtask

   task automatic test_clear_capture();
      int np, nv, ne, fk; logic [3:0] d; logic da, bh;
      pulse_clear();
      sw = 10'd3;
      repeat (4) @(negedge clk);
      np = 0;
      btn_n = 1'b0;
      repeat (7) begin
         @(posedge clk);
         @(negedge clk);
         if (digit_valid || digit_err) np++;
      end
      clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      n_checks++;
      if (digit_valid !== 1'b0 || digit_err !== 1'b0 || entry_count !== 3'd0 || busy !== 1'b1 || np !== 0) begin
         n_fail++; $display("FAIL clear_capture: valid=%b err=%b count=%0d busy=%b early=%0d expected 0/0/0/1/0",
                            digit_valid, digit_err, entry_count, busy, np);
      end
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         if (digit_valid || digit_err) np++;
      end
      n_checks++;
      if (np !== 0 || busy !== 1'b1) begin n_fail++; $display("FAIL clear_hold: pulses=%0d busy=%b expected 0/1", np, busy); end
      btn_n = 1'b1;
      repeat (12) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || entry_done !== 1'b0) begin n_fail++; $display("FAIL clear_release: busy=%b done=%b expected 0/0", busy, entry_done); end
      press_release(10'd9, 10, nv, ne, d, fk, da, bh);
      n_checks++;
      if (nv !== 1 || d !== 4'd9 || entry_count !== 3'd1 || fk !== 8) begin
         n_fail++; $display("FAIL clear_next_press: valid=%0d digit=%0d count=%0d edge=%0d expected 1/9/1/8", nv, d, entry_count, fk);
      end
   endtask

   task automatic test_async_reset();
      int np, nv, ne, fk; logic [3:0] d; logic da, bh;
      sw = 10'd5;
      repeat (4) @(negedge clk);
      btn_n = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      n_checks++;
      if ({digit_valid, digit, digit_err, entry_count, entry_done, busy} !== 11'd0) begin
         n_fail++; $display("FAIL async_reset: got %b expected 0", {digit_valid, digit, digit_err, entry_count, entry_done, busy});
      end
      @(negedge clk);
      rst_n = 1'b0;
      np = 0;
      repeat (25) begin
         @(posedge clk);
         @(negedge clk);
         if (digit_valid || digit_err) np++;
      end
      n_checks++;
      if (np !== 0) begin n_fail++; $display("FAIL reset_held_btn: got %0d pulses expected 0", np); end
      btn_n = 1'b1;
      repeat (12) @(negedge clk);
      press_release(10'd5, 10, nv, ne, d, fk, da, bh);
      n_checks++;
      if (nv !== 1 || d !== 4'd5 || entry_count !== 3'd1) begin
         n_fail++; $display("FAIL reset_next_press: valid=%0d digit=%0d count=%0d expected 1/5/1", nv, d, entry_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic_press();
      test_glitch();
      test_bad_digit();
      test_full_entry();
      test_clear_capture();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/digit_entry.md
Name: digit_entry

Overview:
- Upstream input-conditioning stage for the 6-digit combination-lock FSM on the DE1-SoC.
- Takes a raw active-low pushbutton (KEY) and the 10 slide switches (SW), synchronizes and debounces the button, and validates the switch value as a decimal digit 0-9.
- Emits exactly one digit_valid or digit_err pulse per physical press.
- Counts accepted digits and flags entry_done after the sixth, so the lock FSM consumes clean, single-cycle digit strobes instead of a raw clock key.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required for press/release (1 ms at 50 MHz); must be >= 2.
- CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1.
- NUM_DIGITS, 6, accepted digits per combination before entry_done.

Ports:
- clk  in  1  system clock, all flops rising-edge.
- rst_n  in  1  asynchronous, active-high reset; asserted = 1, despite the suffix.
- btn_n  in  1  raw pushbutton, 0 = pressed, asynchronous to clk.
- sw  in  10  raw slide switches, asynchronous to clk.
- clear  in  1  synchronous, active-high; restarts entry.
- digit_valid  out  1  one-cycle pulse: legal digit accepted.
- digit  out  4  last accepted digit; holds between pulses.
- digit_err  out  1  one-cycle pulse: press with sw > 9.
- entry_count  out  3  digits accepted so far, 0..NUM_DIGITS.
- entry_done  out  1  high while entry_count == NUM_DIGITS.
- busy  out  1  high whenever FSM is not in IDLE or DONE.

Behaviour:
- Reset (async, rst_n=1):
  - All outputs 0.
  - FSM = IDLE, debounce counter 0.
  - Synchronizer flops reset to btn released (1) and sw 0.
- Synchronization: btn_n and sw each pass through 2 flops (btn_sync, sw_sync). No other logic reads the raw inputs.
- FSM states: IDLE, DEB_PRESS, CAPTURE, WAIT_REL, DEB_REL, DONE.
  - IDLE: if btn_sync=0 -> DEB_PRESS, counter cleared to 0.
  - DEB_PRESS:
    - If btn_sync=1 -> IDLE (bounce).
    - Else counter increments; on the edge where the counter == DEBOUNCE_CYCLES-1 -> CAPTURE.
  - CAPTURE: always -> WAIT_REL. On that edge, sw_sync is evaluated as a 10-bit unsigned value:
    - If <= 9: digit <= sw_sync[3:0], digit_valid <= 1, entry_count++.
    - Else: digit_err <= 1; digit and entry_count unchanged.
  - WAIT_REL: if btn_sync=1 -> DEB_REL, counter cleared.
  - DEB_REL:
    - If btn_sync=0 -> WAIT_REL.
    - Else on counter == DEBOUNCE_CYCLES-1 -> DONE if entry_count == NUM_DIGITS, otherwise IDLE.
  - DONE: button ignored; stays until clear.
- Pulses: digit_valid and digit_err are registered, high for exactly one cycle, and never both high.
- Latency: digit_valid/digit_err rise after clock edge DEBOUNCE_CYCLES+4, counting the first edge that samples btn_n=0 as edge 1, with btn_n held low throughout.
- Release: a held button produces only one pulse. A new press is recognized only after a full debounced release.
- entry_done: entry_done = (entry_count == NUM_DIGITS), registered. Asserts one cycle after the final digit_valid. entry_count saturates and never exceeds NUM_DIGITS.
- clear (has priority over every transition in the same cycle):
  - entry_count <= 0, counter <= 0, and any pending pulse is suppressed (clear during CAPTURE yields no pulse).
  - Next state is WAIT_REL if btn_sync=0, else IDLE, so a button held across clear does not generate a digit.
- Async reset mid-press: immediate return to reset values; the press in progress is discarded.
- busy = state is not IDLE and not DONE.

Test Plan:
- DEBOUNCE_CYCLES=4, sw=7, btn_n low for 20 cycles then high -> digit_valid high only after edge 8, digit=7, entry_count=1, no second pulse during the hold.
- btn_n glitch low for 3 cycles (shorter than debounce), then high -> no pulse, FSM back in IDLE, busy returns to 0.
- sw=10'd12, full press/release -> digit_err one cycle, digit_valid 0, digit keeps previous value, entry_count unchanged.
- Six clean presses with sw = 7,0,3,2,6,2 -> six digit_valid pulses with matching digit; entry_done=1 one cycle after the sixth; a seventh press gives no pulse and entry_count stays 6.
- clear asserted in the CAPTURE cycle while btn held -> no pulse, entry_count=0; FSM waits for release; the next press yields a normal pulse.
- rst_n pulsed asynchronously mid-DEB_PRESS -> all outputs 0 immediately, no pulse after reset is released while btn still held until a release/press sequence completes.
